// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and counter sizing for the sequential divider
package div_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, OP = 2'b01, FIX = 2'b10, DONE = 2'b11} state_t;
    localparam int CNT_EXTRA = 1;
endpackage

// File: rtl/div_cmp_sub.sv
// div_cmp_sub: one restoring compare-subtract step on a W+1-bit shifted partial remainder
module div_cmp_sub #(
    parameter int W = 8
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] dvsr_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);
    logic [W:0] diff;
    always_comb begin
        diff  = rem_i - {1'b0, dvsr_i};
        q_o   = rem_i >= {1'b0, dvsr_i};
        rem_o = q_o ? diff[W-1:0] : rem_i[W-1:0];
    end
endmodule

// File: rtl/div_seq_param.sv
// div_seq_param: W-cycle restoring divider, signed or unsigned, with divide-by-zero and overflow flags
module div_seq_param
    import div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [W-1:0] dvnd,
    input  logic [W-1:0] dvsr,
    output logic         ready,
    output logic         done_tick,
    output logic [W-1:0] quo,
    output logic [W-1:0] rmd,
    output logic         dbz,
    output logic         ovf
);
    localparam int CBIT = $clog2(W) + CNT_EXTRA;

    state_t          state_q, state_d;
    logic [W-1:0]    quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic [CBIT-1:0] cnt_q, cnt_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d, ovf_q, ovf_d;
    logic [W-1:0]    step_rem, dvnd_abs, dvsr_abs;
    logic            step_q, dvnd_neg, dvsr_neg;

    // quo_q doubles as the dividend shift register while iterating
    div_cmp_sub #(.W(W)) u_step (
        .rem_i ({rem_q, quo_q[W-1]}),
        .dvsr_i(dvsr_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        dvnd_neg = signed_mode & dvnd[W-1];
        dvsr_neg = signed_mode & dvsr[W-1];
        dvnd_abs = dvnd_neg ? -dvnd : dvnd;
        dvsr_abs = dvsr_neg ? -dvsr : dvsr;
        state_d  = state_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                dvsr_d  = dvsr_abs;
                cnt_d   = '0;
                qneg_d  = dvnd_neg ^ dvsr_neg;
                rneg_d  = dvnd_neg;
                dbz_d   = dvsr == '0;
                ovf_d   = signed_mode && dvnd == {1'b1, {(W-1){1'b0}}} && dvsr == '1;
                quo_d   = dbz_d ? '1 : dvnd_abs;
                rem_d   = dbz_d ? dvnd : '0;
                state_d = dbz_d ? DONE : OP;
            end
            OP: begin
                quo_d   = {quo_q[W-2:0], step_q};
                rem_d   = step_rem;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CBIT'(W - 1) ? FIX : OP;
            end
            FIX: begin
                quo_d   = qneg_q ? -quo_q : quo_q;
                rem_d   = rneg_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready     = state_q == IDLE;
    assign done_tick = state_q == DONE;
    assign quo       = quo_q;
    assign rmd       = rem_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_div_seq_param.sv
// tb_div_seq_param: scoreboard bench for div_seq_param with an integer reference model
module tb_div_seq_param;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, start, signed_mode;
    logic [W-1:0] dvnd, dvsr;
    logic         ready, done_tick, dbz, ovf;
    logic [W-1:0] quo, rmd;

    exp_t sb[$];
    int   n_tests = 0, n_fail = 0, n_done = 0, cyc = 0, last_done = -1;
    logic b2b = 1'b0;

    div_seq_param #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_mode(signed_mode),
        .dvnd       (dvnd),
        .dvsr       (dvsr),
        .ready      (ready),
        .done_tick  (done_tick),
        .quo        (quo),
        .rmd        (rmd),
        .dbz        (dbz),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   ia, ib;
        e = '{q: '0, r: '0, dbz: 1'b0, ovf: 1'b0, cyc: 0};
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            return e;
        end
        ia    = sm ? int'($signed(a)) : int'(a);
        ib    = sm ? int'($signed(b)) : int'(b);
        e.q   = W'(ia / ib);
        e.r   = W'(ia % ib);
        e.ovf = sm && ia == -(1 << (W - 1)) && ib == -1;
        return e;
    endfunction

    // called on the falling edge just before the accepting rising edge
    task automatic push_exp(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e     = model(sm, a, b);
        e.cyc = cyc + 1 + ((b == '0) ? 0 : W + 1);
        sb.push_back(e);
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] edge_v[4];
        edge_v = '{8'h80, 8'hFF, 8'h01, 8'h7F};
        return ($urandom_range(0, 7) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
    endfunction

    always @(negedge clk) begin
        if (!reset && done_tick) begin
            if (sb.size() == 0) begin
                chk("spurious_done", done_tick, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quo", quo, e.q);
                chk("rmd", rmd, e.r);
                chk("dbz", dbz, e.dbz);
                chk("ovf", ovf, e.ovf);
                chk("latency", cyc, e.cyc);
                chk("ready_in_done", ready, 1'b0);
                if (b2b && last_done >= 0) chk("b2b_gap", cyc - last_done, W + 3);
                last_done = cyc;
            end
            n_done++;
        end
    end

    task automatic wait_done(input int s);
        for (int i = 0; i < 4 * W && n_done == s; i++) @(posedge clk);
        if (n_done == s) chk("done_timeout", n_done, s + 1);
    endtask

    task automatic run_dir(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edbz, input logic eovf);
        int s;
        s = n_done;
        @(negedge clk);
        signed_mode = sm;
        dvnd        = a;
        dvsr        = b;
        start       = 1'b1;
        push_exp(sm, a, b);
        @(negedge clk);
        dvnd        = ~a;
        dvsr        = b + 1'b1;
        signed_mode = ~sm;
        @(negedge clk);
        start = 1'b0;
        wait_done(s);
        @(negedge clk);
        @(negedge clk);
        chk("hold_quo", quo, eq);
        chk("hold_rmd", rmd, er);
        chk("hold_dbz", dbz, edbz);
        chk("hold_ovf", ovf, eovf);
        chk("idle_ready", ready, 1'b1);
    endtask

    initial begin
        int s, pushed;
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        dvnd        = '0;
        dvsr        = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done_tick, 1'b0);
        chk("rst_quo", quo, 0);
        chk("rst_rmd", rmd, 0);
        chk("rst_dbz", dbz, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        reset = 1'b0;

        run_dir(1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
        run_dir(1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0);
        run_dir(1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0);
        run_dir(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
        run_dir(1'b0, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
        run_dir(1'b0, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b0);
        run_dir(1'b1, 8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1'b0);
        run_dir(1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0);
        run_dir(1'b1, 8'h81, 8'h7F, 8'hFF, 8'h00, 1'b0, 1'b0);

        // abandon a division with reset in its third OP cycle
        s = n_done;
        @(negedge clk);
        signed_mode = 1'b0;
        dvnd        = 8'd200;
        dvsr        = 8'd7;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        dvnd  = 8'd1;
        dvsr  = 8'd1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_quo", quo, 0);
        chk("mid_rst_rmd", rmd, 0);
        chk("mid_rst_dbz", dbz, 1'b0);
        chk("mid_rst_ovf", ovf, 1'b0);
        chk("mid_rst_done", done_tick, 1'b0);
        repeat (2 * W) @(negedge clk);
        chk("mid_rst_no_done", n_done - s, 0);

        // back-to-back with start held high and fresh operands every cycle
        b2b       = 1'b1;
        last_done = -1;
        pushed    = 0;
        for (int i = 0; i < 20000 && pushed < 1000; i++) begin
            @(negedge clk);
            signed_mode = 1'($urandom_range(0, 1));
            dvnd        = rnd_op();
            dvsr        = rnd_op();
            if (dvsr == '0) dvsr = 8'd1;
            start = 1'b1;
            if (ready) begin
                push_exp(signed_mode, dvnd, dvsr);
                pushed++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4 * W && sb.size() != 0; i++) @(negedge clk);
        chk("b2b_count", pushed, 1000);
        chk("drain", sb.size(), 0);
        b2b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_seq_param.md
DIV_SEQ_PARAM -- requirements
Module: div_seq_param

Interface
REQ-001 The block SHALL have parameter W, default 8, giving operand and result width (W >= 4).
REQ-002 The block SHALL derive localparam CBIT = $clog2(W)+1 for the iteration counter; CBIT SHALL NOT be a user parameter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request to begin a division.
REQ-006 The block SHALL have port signed_mode, input, 1: 1 = two's-complement operands, 0 = unsigned.
REQ-007 The block SHALL have port dvnd, input, W, the dividend.
REQ-008 The block SHALL have port dvsr, input, W, the divisor.
REQ-009 The block SHALL have port ready, output, 1, high only in IDLE.
REQ-010 The block SHALL have port done_tick, output, 1, a one-cycle pulse when results are valid.
REQ-011 The block SHALL have ports quo and rmd, output, W each, the quotient and remainder.
REQ-012 The block SHALL have port dbz, output, 1, the divide-by-zero flag.
REQ-013 The block SHALL have port ovf, output, 1, the signed-overflow flag.

Function
REQ-014 The FSM SHALL have states IDLE, OP, FIX and DONE; ready = (IDLE) and done_tick = (DONE), both decoded combinationally from the state.
REQ-015 In IDLE with start=1, the block SHALL capture dvnd, dvsr and signed_mode, and clear dbz and ovf.
REQ-016 When signed_mode=1, the captured values SHALL be absolute magnitudes, with result signs recorded: quotient negative = sign(dvnd) XOR sign(dvsr); remainder sign = sign(dvnd).
REQ-017 A start accepted with dvsr=0 SHALL go IDLE->DONE directly, with quo = all ones, rmd = dvnd unmodified, and dbz=1.
REQ-018 Otherwise the FSM SHALL go IDLE->OP and perform exactly W restoring compare-subtract-shift iterations, one per cycle, using a W+1-bit partial remainder so unsigned divisors up to 2^W-1 do not overflow.
REQ-019 After the W-th iteration, the FSM SHALL go OP->FIX; in FIX it SHALL apply the recorded signs (two's-complement negate) to the quotient and remainder, then go FIX->DONE.
REQ-020 Quotient SHALL truncate toward zero; remainder SHALL satisfy dvnd = quo*dvsr + rmd with |rmd| < |dvsr|.
REQ-021 Signed dvnd = -2^(W-1) with dvsr = -1 SHALL yield quo = -2^(W-1) (wrapped), rmd = 0, ovf=1; no other case sets ovf.
REQ-022 Latency: for a start sampled at edge k with dvsr != 0, done_tick SHALL be high in cycle k+W+2; for dvsr=0, in cycle k+1.
REQ-023 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-024 quo, rmd, dbz and ovf SHALL hold their final values from DONE until the next accepted start.
REQ-025 start SHALL be ignored outside IDLE; operand changes after capture SHALL NOT affect the result.
REQ-026 start asserted in the cycle DONE is left SHALL NOT be accepted until the block is in IDLE (ready=1).
REQ-027 The block SHALL support back-to-back operations: start held high SHALL begin a new division on every IDLE cycle.

Reset
REQ-028 While reset=1 at a clock edge, the state SHALL become IDLE and quo, rmd, dbz, ovf and all internal registers SHALL become 0; this takes precedence over start.
REQ-029 Reset asserted mid-operation (OP or FIX) SHALL abandon the division with no done_tick generated.

Structure
REQ-030 Package div_pkg SHALL hold the state typedef (2-bit encoding: IDLE=00, OP=01, FIX=10, DONE=11) and a helper constant for the CBIT derivation.
REQ-031 The single compare-subtract step SHALL be a sub-module div_cmp_sub (inputs: partial remainder, divisor; outputs: next remainder, quotient bit), purely combinational.
REQ-032 The top level SHALL contain one sequential process for state and data registers and one combinational next-state/datapath process.

Verification
REQ-033 With W=8, unsigned 200/7 -> quo=28, rmd=4, done_tick in cycle k+10, dbz=0, ovf=0.
REQ-034 With W=8, signed -7/2 (0xF9/0x02) -> quo=0xFD, rmd=0xFF; signed 7/-2 -> quo=0xFD, rmd=0x01.
REQ-035 With W=8, signed 0x80/0xFF -> quo=0x80, rmd=0x00, ovf=1; unsigned 255/255 -> quo=1, rmd=0.
REQ-036 Divide by zero: dvnd=0x55, dvsr=0 -> done_tick in cycle k+1, quo=0xFF, rmd=0x55, dbz=1.
REQ-037 Reset pulse in OP cycle 3 -> ready=1 the next cycle, all outputs 0, no done_tick; start pulses during OP are ignored.
REQ-038 With start held high, two consecutive divisions SHALL produce done_tick pulses exactly W+3 cycles apart, checked against a reference model over 1000 random operand pairs in both modes.
